// File: rtl/jam_pkg.sv
// Shared constants, types and helpers for the JAM cost-table front end.
package jam_pkg;

  localparam int unsigned N_SIDE = 8;
  localparam int unsigned COST_W = 7;
  localparam int unsigned LB_W   = 10;
  localparam int unsigned DEPTH  = N_SIDE * N_SIDE;

  typedef logic [5:0]        addr_t;
  typedef logic [COST_W-1:0] cost_t;

  typedef enum logic [1:0] {IDLE, LOAD, READY} tbl_state_t;

  function automatic cost_t min_cost(input cost_t a, input cost_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// 64-entry cost storage: synchronous write, combinational read, no reset on contents.
module jam_cost_mem
  import jam_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  cost_t wdata,
  input  addr_t raddr,
  output cost_t rdata
);

  cost_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/jam_cost_table.sv
// Loadable 8x8 worker/job cost table feeding JAM; gates JAM reset until a full table is loaded
// and accumulates the sum of row minima as a lower bound.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            load_start,
  input  logic            wr_valid,
  input  logic [COST_W-1:0] wr_data,
  output logic            wr_ready,
  input  logic [2:0]      W,
  input  logic [2:0]      J,
  output logic [COST_W-1:0] Cost,
  output logic            tbl_ready,
  output logic            jam_rst,
  output logic [LB_W-1:0] LowerBound
);

  tbl_state_t      state_q, state_d;
  addr_t           wr_ptr_q, wr_ptr_d;
  cost_t           rmin_q, rmin_d;
  logic [LB_W-1:0] lb_q, lb_d;
  logic [2:0]      w_q, j_q;
  logic            we;
  cost_t           row_min;

  // First beat of a row seeds the minimum; later beats fold into it.
  assign row_min = (wr_ptr_q[2:0] == 3'd0) ? wr_data : min_cost(rmin_q, wr_data);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rmin_d   = rmin_q;
    lb_d     = lb_q;
    we       = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          lb_d     = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          // Restart takes priority; a beat presented on this edge is dropped.
          wr_ptr_d = '0;
          lb_d     = '0;
        end else if (wr_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 6'd1;
          rmin_d   = row_min;
          if (wr_ptr_q[2:0] == 3'd7) begin
            lb_d = lb_q + LB_W'(row_min);
          end
          if (wr_ptr_q == 6'd63) begin
            state_d = READY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rmin_q   <= '0;
      lb_q     <= '0;
      w_q      <= '0;
      j_q      <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rmin_q   <= rmin_d;
      lb_q     <= lb_d;
      w_q      <= W;
      j_q      <= J;
    end
  end

  jam_cost_mem u_mem (
    .clk   (CLK),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr ({w_q, j_q}),
    .rdata (Cost)
  );

  assign wr_ready   = (state_q == LOAD);
  assign tbl_ready  = (state_q == READY);
  assign jam_rst    = ~tbl_ready;
  assign LowerBound = lb_q;

endmodule
